fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single write port of the 8-deep, 32-bit synchronous FIFO among several producers. Each producer presents a valid/ready stream; the arbiter grants one producer at a time for a bounded burst, steers its data onto the FIFO write port, and respects FIFO full and the FIFO's read-over-write priority. It sits directly in front of the FIFO's `d_in`/`wr_en` inputs.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default widths for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: scans valid starting at 'start', wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic          hit,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Rotate so that 'start' lands at bit 0, then take the lowest set bit.
    assign dbl = {valid, valid};
    assign rot = N'(dbl >> start);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        sum = '0;
        for (int k = 0; k < N; k++) begin
            if (!hit && rot[k]) begin
                hit = 1'b1;
                sum = {1'b0, start} + (IW+1)'(k);
                if (sum >= (IW+1)'(N))
                    sum = sum - (IW+1)'(N);
                idx = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin bursting arbiter in front of the shared FIFO write port.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = fifo_wr_arbiter_pkg::DATA_W,
    parameter int MAX_BURST = 4,
    localparam int IW       = idx_w(N_REQ),
    localparam int CW       = $clog2(MAX_BURST) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    input  logic                    fifo_rd_en,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_d_in,
    output logic [IW-1:0]           grant_id,
    output logic                    busy
);

    arb_state_t                     state, state_nxt;
    logic [IW-1:0]                  grant_nxt;
    logic [IW-1:0]                  rr_ptr, rr_nxt;
    logic [CW-1:0]                  beat_cnt, cnt_nxt;
    logic [N_REQ-1:0][DATA_W-1:0]   data_v;
    logic [IW-1:0]                  search_start;
    logic                           pick_hit;
    logic [IW-1:0]                  pick_idx;
    logic                           grant_valid;
    logic                           beat_open;
    logic                           beat;
    logic                           last_beat;

    assign data_v       = req_data;
    assign search_start = (rr_ptr == IW'(N_REQ-1)) ? '0 : rr_ptr + 1'b1;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .valid (req_valid),
        .start (search_start),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    // Ready depends only on FIFO status and enable, never on our own write strobe.
    assign grant_valid = req_valid[grant_id];
    assign beat_open   = (state == BURST) & en & ~fifo_full & ~fifo_rd_en;
    assign beat        = beat_open & grant_valid;
    assign last_beat   = (beat_cnt == CW'(MAX_BURST-1));

    always_comb begin
        req_ready = '0;
        if (beat_open)
            req_ready[grant_id] = 1'b1;
    end

    assign fifo_wr_en = beat;
    assign fifo_d_in  = data_v[grant_id];
    assign busy       = (state == BURST);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        if (en) begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        state_nxt = BURST;
                        grant_nxt = pick_idx;
                        rr_nxt    = pick_idx;
                        cnt_nxt   = '0;
                    end
                end
                BURST: begin
                    if (beat) begin
                        cnt_nxt = beat_cnt + 1'b1;
                        if (last_beat)
                            state_nxt = IDLE;
                    end else if (!grant_valid) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // rr_ptr resets to the top index so the first search begins at requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= IW'(N_REQ-1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

endmodule
